// File: rtl/ps2_mouse_receiver_if.sv
// ps2_mouse_receiver_if
// Bundles the PS/2 receive path signals between the mouse master state
// machine (master) and the frame receiver (slave).
//   CLK_MOUSE_IN    PS/2 clock line, asynchronous, idle high
//   DATA_MOUSE_IN   PS/2 data line, asynchronous, idle high
//   READ_ENABLE     level, high permits frame reception
//   BYTE_READ       last received data byte
//   BYTE_ERROR_CODE bit0 parity error, bit1 stop-bit error (valid with strobe)
//   BYTE_READY      single-cycle strobe
//   RX_STATE        receiver state encoding for debug/LEDs
interface ps2_mouse_receiver_if;
    logic       CLK_MOUSE_IN;
    logic       DATA_MOUSE_IN;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;
    logic [2:0] RX_STATE;

    modport master (
        output CLK_MOUSE_IN,
        output DATA_MOUSE_IN,
        output READ_ENABLE,
        input  BYTE_READ,
        input  BYTE_ERROR_CODE,
        input  BYTE_READY,
        input  RX_STATE
    );

    modport slave (
        input  CLK_MOUSE_IN,
        input  DATA_MOUSE_IN,
        input  READ_ENABLE,
        output BYTE_READ,
        output BYTE_ERROR_CODE,
        output BYTE_READY,
        output RX_STATE
    );
endinterface

// File: rtl/ps2_mouse_receiver.sv
// ps2_mouse_receiver
// Receive path of the PS/2 mouse interface: synchronises the mouse clock and
// data lines into CLK, detects falling edges of the mouse clock and deframes
// 11-bit device-to-host frames (start, D0..D7, odd parity, stop).
//   CLK    system clock
//   RESET  synchronous, active-high reset
//   bus    ps2_mouse_receiver_if.slave (lines in, byte/strobe/state out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a start bit (data low at clock fall, enabled)
// DATA   | shifting in D0..D7, LSB first
// PARITY | sampling the parity bit, latching the parity error
// STOP   | sampling the stop bit, latching the stop-bit error
// DONE   | one cycle: present byte + error code, pulse BYTE_READY
module ps2_mouse_receiver #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    ps2_mouse_receiver_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_TC = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic          clk_sync1;
    logic          clk_sync2;
    logic          clk_prev;
    logic          data_sync1;
    logic          data_sync2;
    logic          fedge;

    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_err;
    logic          stop_err;
    logic [TW-1:0] timeout_cnt;
    logic          timeout_hit;
    logic          accept;

    logic [7:0]    byte_read;
    logic [1:0]    byte_error_code;
    logic          byte_ready;

    logic          frame_active;
    logic          load_byte;

    // Synchronisers reset high so an idle bus produces no edge after reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_sync1  <= 1'b1;
            clk_sync2  <= 1'b1;
            clk_prev   <= 1'b1;
            data_sync1 <= 1'b1;
            data_sync2 <= 1'b1;
        end else begin
            clk_sync1  <= bus.CLK_MOUSE_IN;
            clk_sync2  <= clk_sync1;
            clk_prev   <= clk_sync2;
            data_sync1 <= bus.DATA_MOUSE_IN;
            data_sync2 <= data_sync1;
        end
    end

    assign fedge       = clk_prev & ~clk_sync2;
    assign timeout_hit = (timeout_cnt == TIMEOUT_TC);
    // A timeout wins over an edge arriving in the same cycle.
    assign accept      = fedge & bus.READ_ENABLE & ~timeout_hit;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE: begin
                if (accept && !data_sync2) begin
                    state_next = S_DATA;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (!bus.READ_ENABLE || timeout_hit) begin
                    state_next = S_IDLE;
                end else if (fedge && bit_cnt == 3'd7) begin
                    state_next = S_PARITY;
                end else begin
                    state_next = S_DATA;
                end
            end
            S_PARITY: begin
                if (!bus.READ_ENABLE || timeout_hit) begin
                    state_next = S_IDLE;
                end else if (fedge) begin
                    state_next = S_STOP;
                end else begin
                    state_next = S_PARITY;
                end
            end
            S_STOP: begin
                if (!bus.READ_ENABLE || timeout_hit) begin
                    state_next = S_IDLE;
                end else if (fedge) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_STOP;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        frame_active = 1'b0;
        load_byte    = 1'b0;
        bus.RX_STATE = state;
        case (state)
            S_DATA, S_PARITY, S_STOP: frame_active = 1'b1;
            S_DONE:                   load_byte    = 1'b1;
            default: begin
                frame_active = 1'b0;
                load_byte    = 1'b0;
            end
        endcase
    end

    // Inter-edge watchdog; cleared on its own terminal count so it never wraps.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            timeout_cnt <= '0;
        end else if (!frame_active || fedge || timeout_hit) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    // Frame datapath
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_err <= 1'b0;
            stop_err   <= 1'b0;
        end else if (accept) begin
            case (state)
                S_IDLE: begin
                    if (!data_sync2) begin
                        bit_cnt    <= 3'd0;
                        shift_reg  <= 8'h00;
                        parity_err <= 1'b0;
                        stop_err   <= 1'b0;
                    end
                end
                S_DATA: begin
                    shift_reg[bit_cnt] <= data_sync2;
                    bit_cnt            <= bit_cnt + 3'd1;
                end
                // Odd parity: XOR over D0..D7 and the parity bit must be 1.
                S_PARITY: parity_err <= ~(^{shift_reg, data_sync2});
                S_STOP:   stop_err   <= ~data_sync2;
                default: ;
            endcase
        end
    end

    // Registered outputs: byte held until next DONE, error code only with strobe.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            byte_read       <= 8'h00;
            byte_error_code <= 2'b00;
            byte_ready      <= 1'b0;
        end else if (load_byte) begin
            byte_read       <= shift_reg;
            byte_error_code <= {stop_err, parity_err};
            byte_ready      <= 1'b1;
        end else begin
            byte_error_code <= 2'b00;
            byte_ready      <= 1'b0;
        end
    end

    assign bus.BYTE_READ       = byte_read;
    assign bus.BYTE_ERROR_CODE = byte_error_code;
    assign bus.BYTE_READY      = byte_ready;

endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// tb_ps2_mouse_receiver
// Drives PS/2 frames into ps2_mouse_receiver and checks received bytes,
// error codes, strobe latency and state against a frame-level model.
module tb_ps2_mouse_receiver;

    localparam int TO   = 200;
    localparam int HALF = 25;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    ps2_mouse_receiver_if bus();

    ps2_mouse_receiver #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int stop_fall_cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Strobe recorder: captures every BYTE_READY cycle plus protocol violations.
    int         sq_cyc[$];
    logic [7:0] sq_byte[$];
    logic [1:0] sq_err[$];
    int         err_outside = 0;
    int         width_viol  = 0;
    logic       ready_prev  = 1'b0;

    always @(negedge CLK) begin
        if (bus.BYTE_READY === 1'b1) begin
            sq_cyc.push_back(cyc);
            sq_byte.push_back(bus.BYTE_READ);
            sq_err.push_back(bus.BYTE_ERROR_CODE);
            if (ready_prev) width_viol++;
        end else if (bus.BYTE_READY === 1'b0 && bus.BYTE_ERROR_CODE !== 2'b00) begin
            err_outside++;
        end
        ready_prev = (bus.BYTE_READY === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Reference frame: start 0, D0..D7, odd parity (optionally corrupted), stop.
    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit par_bad, input bit stop_bad);
        logic par;
        par = (($countones(d) % 2) == 0);
        par = par ^ par_bad;
        return {~stop_bad, par, d, 1'b0};
    endfunction

    // Error code implied by the frame bits as they appear on the wire.
    function automatic logic [1:0] exp_err(input logic [10:0] f);
        logic [8:0] dp;
        logic       pe;
        logic       se;
        dp = f[9:1];
        pe = (($countones(dp) % 2) == 0);
        se = (f[10] == 1'b0);
        return {se, pe};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.DATA_MOUSE_IN = f[i];
            wait_clk(HALF);
            bus.CLK_MOUSE_IN = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            wait_clk(HALF);
            bus.CLK_MOUSE_IN = 1'b1;
        end
        bus.DATA_MOUSE_IN = 1'b1;
    endtask

    task automatic clear_q();
        sq_cyc.delete();
        sq_byte.delete();
        sq_err.delete();
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] d, input logic [1:0] e);
        int lat;
        check($sformatf("%s_count", tag), sq_byte.size(), 1);
        if (sq_byte.size() > 0) begin
            lat = sq_cyc[0] - stop_fall_cyc;
            check($sformatf("%s_byte", tag), {24'h0, sq_byte[0]}, {24'h0, d});
            check($sformatf("%s_err", tag), {30'h0, sq_err[0]}, {30'h0, e});
            check($sformatf("%s_latency", tag), (lat >= 4 && lat <= 5), 1);
        end
        check($sformatf("%s_hold", tag), {24'h0, bus.BYTE_READ}, {24'h0, d});
        check($sformatf("%s_err_after", tag), {30'h0, bus.BYTE_ERROR_CODE}, 32'h0);
        clear_q();
    endtask

    task automatic expect_none(input string tag);
        check($sformatf("%s_nostrobe", tag), sq_byte.size(), 0);
        clear_q();
    endtask

    logic [10:0] f;
    logic [7:0]  rd;
    bit          pb;
    bit          sb;

    initial begin
        bus.CLK_MOUSE_IN  = 1'b1;
        bus.DATA_MOUSE_IN = 1'b1;
        bus.READ_ENABLE   = 1'b1;
        RESET = 1'b1;
        wait_clk(3);
        check("rst_byte", {24'h0, bus.BYTE_READ}, 32'h0);
        check("rst_err", {30'h0, bus.BYTE_ERROR_CODE}, 32'h0);
        check("rst_ready", {31'h0, bus.BYTE_READY}, 32'h0);
        check("rst_state", {29'h0, bus.RX_STATE}, 32'h0);
        RESET = 1'b0;
        wait_clk(10);

        // Valid frames, back to back
        f = make_frame(8'hFA, 0, 0); send_bits(f, 0, 10); wait_clk(2); expect_byte("fa", 8'hFA, 2'b00);
        f = make_frame(8'hAA, 0, 0); send_bits(f, 0, 10); wait_clk(2); expect_byte("aa", 8'hAA, 2'b00);
        f = make_frame(8'h00, 0, 0); send_bits(f, 0, 10); wait_clk(2); expect_byte("00", 8'h00, 2'b00);

        // Error frames
        f = make_frame(8'hF4, 1, 0); send_bits(f, 0, 10); wait_clk(2); expect_byte("par", 8'hF4, 2'b01);
        f = make_frame(8'h08, 0, 1); send_bits(f, 0, 10); wait_clk(2); expect_byte("stop", 8'h08, 2'b10);
        f = make_frame(8'h3C, 1, 1); send_bits(f, 0, 10); wait_clk(2); expect_byte("both", 8'h3C, 2'b11);

        // Clock stalls after 4 data bits: still receiving before the limit, idle after
        f = make_frame(8'h99, 0, 0);
        send_bits(f, 0, 4);
        check("to_active", {29'h0, bus.RX_STATE}, 32'd1);
        wait_clk(160);
        check("to_before", {29'h0, bus.RX_STATE}, 32'd1);
        wait_clk(40);
        check("to_after", {29'h0, bus.RX_STATE}, 32'd0);
        wait_clk(100);
        expect_none("to");
        f = make_frame(8'h55, 0, 0); send_bits(f, 0, 10); wait_clk(2); expect_byte("55", 8'h55, 2'b00);

        // READ_ENABLE low for a whole frame
        bus.READ_ENABLE = 1'b0;
        f = make_frame(8'h12, 0, 0); send_bits(f, 0, 10); wait_clk(5);
        expect_none("re_low");
        check("re_low_state", {29'h0, bus.RX_STATE}, 32'd0);
        bus.READ_ENABLE = 1'b1;
        wait_clk(5);

        // READ_ENABLE dropped mid-frame
        f = make_frame(8'h5A, 0, 0);
        send_bits(f, 0, 2);
        check("re_drop_active", {29'h0, bus.RX_STATE}, 32'd1);
        bus.READ_ENABLE = 1'b0;
        wait_clk(1);
        check("re_drop_state", {29'h0, bus.RX_STATE}, 32'd0);
        send_bits(f, 3, 10);
        wait_clk(5);
        expect_none("re_drop");
        bus.READ_ENABLE = 1'b1;
        wait_clk(5);

        // RESET mid-frame; remaining bits of 0xFA after D3 are all ones
        check("pre_rst_byte", {24'h0, bus.BYTE_READ}, 32'h55);
        f = make_frame(8'hFA, 0, 0);
        send_bits(f, 0, 4);
        check("mid_rst_active", {29'h0, bus.RX_STATE}, 32'd1);
        RESET = 1'b1;
        wait_clk(1);
        RESET = 1'b0;
        check("mid_rst_byte", {24'h0, bus.BYTE_READ}, 32'h0);
        check("mid_rst_err", {30'h0, bus.BYTE_ERROR_CODE}, 32'h0);
        check("mid_rst_ready", {31'h0, bus.BYTE_READY}, 32'h0);
        check("mid_rst_state", {29'h0, bus.RX_STATE}, 32'd0);
        send_bits(f, 5, 10);
        wait_clk(5);
        expect_none("mid_rst");
        f = make_frame(8'hFA, 0, 0); send_bits(f, 0, 10); wait_clk(2); expect_byte("fa2", 8'hFA, 2'b00);

        // Randomized frames with occasional parity/stop corruption
        for (int n = 0; n < 12; n++) begin
            rd = 8'($urandom_range(0, 255));
            pb = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 3) == 0);
            f  = make_frame(rd, pb, sb);
            send_bits(f, 0, 10);
            wait_clk(2);
            expect_byte($sformatf("rnd%0d", n), rd, exp_err(f));
        end

        wait_clk(10);
        check("err_outside_strobe", err_outside, 0);
        check("strobe_width", width_viol, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
